sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Single-clock arbiter that shares one SRAM controller request port between NUM_REQ board-clocked requesters. Requesters use a valid/ready handshake; the arbiter grants one request per BOARD_CLK cycle in round-robin order and forwards it as a one-cycle read or write queue pulse. It records the requester index of each read in an in-order tag FIFO and routes each returned read word back to its requester. It sits between the pixel/CPU-side clients and one port of the dual-clock SRAM controller.

## Interface
- NUM_REQ, 4: number of requesters; must be 2..8.
- MAX_OUT, 8: maximum reads in flight; depth of the tag FIFO; power of two.
- BURST_LEN, 4: maximum beats per locked grant; only used with SRAM_ARB_BURST_EN.
- BOARD_CLK  in  1  sole clock; all logic is on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- ReqValid  in  NUM_REQ  request pending, per requester.
- ReqWrite  in  NUM_REQ  1 = write, 0 = read.
- ReqLock  in  NUM_REQ  request to hold the grant for a burst; ignored without the macro.
- ReqAddr  in  NUM_REQ x 20  word address.
- ReqData  in  NUM_REQ x 16  write data.
- ReqReady  out  NUM_REQ  combinational; at most one bit is high.
- RespValid  out  NUM_REQ  one-cycle read-return pulse.
- RespData  out  NUM_REQ x 16  read word; holds its value until the next return to that requester.
- SramReadReq, SramWriteReq  out  1 each  one-cycle queue pulse; the two are mutually exclusive.
- SramAddr  out  20, SramData  out  16  request payload; valid while either pulse is high.
- SramFull  in  1  controller queue cannot accept a request.
- SramRespValid  in  1, SramRespData  in  16  read returns; BOARD_CLK-synchronous and in issue order.
- Outstanding  out  $clog2(MAX_OUT)+1  tag FIFO occupancy.
- RespError  out  1  sticky; set when a return arrives while the tag FIFO is empty.

## Operation
- Handshake: a transfer occurs on a cycle where ReqValid[i] and ReqReady[i] are both high. ReqValid must stay high, with the payload stable, until the transfer.
- Eligibility: requester i is eligible when all of the following hold:
  - ReqValid[i] is high;
  - SramFull is low;
  - for a read, the tag FIFO is not full, or a tag pop occurs in the same cycle.
- Writes are eligible even when the tag FIFO is full.
- Round-robin search:
  - Start at (last_grant+1) mod NUM_REQ and wrap around.
  - The first eligible requester gets ReqReady.
  - last_grant updates only on a transfer.
- Issue: on a transfer, the payload is registered. Next cycle, exactly one of SramReadReq/SramWriteReq pulses, carrying SramAddr/SramData.
- Tag FIFO: a read transfer pushes the requester index. SramRespValid pops the FIFO.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
  - A pop on an empty FIFO sets RespError, and the returned data is dropped.
- Return: the popped index i selects the destination. RespValid[i] pulses and RespData[i] loads SramRespData.
- Reset (asynchronous) clears:
  - all pulses, RespValid, RespData, RespError and Outstanding to 0;
  - last_grant to NUM_REQ-1, so requester 0 has first priority.
- Reads in flight across a reset are lost; their returns set RespError.
- States with the macro:
  - ARB: normal round-robin.
  - LOCKED: the current owner keeps the grant; beat counter cnt.
- Transitions:
  - ARB→LOCKED: a transfer with ReqLock high; cnt=1.
  - LOCKED: each owner transfer increments cnt. The block returns to ARB after the transfer that makes cnt==BURST_LEN, or on any cycle where the owner's ReqValid or ReqLock is low.
  - In LOCKED, only the owner can receive ReqReady. Eligibility rules still apply; a stall holds LOCKED.

## Timing
- Request to Sram*Req: 1 cycle (registered output).
- Throughput: one transfer per cycle when eligible.
- SramRespValid to RespValid: 1 cycle.
- ReqReady is combinational from ReqValid, ReqWrite, SramFull, tag FIFO state and arbiter state. It has no dependence on the Sram*Req outputs.
- SramFull is sampled in the same cycle as the grant. The controller must absorb the single in-flight issue cycle.

## Configuration
- SRAM_ARB_BURST_EN defined: the LOCKED state, the burst counter and ReqLock are present. Bursts are bounded to BURST_LEN beats.
- SRAM_ARB_BURST_EN undefined: ReqLock is ignored and there is no LOCKED state. Every transfer rotates the round-robin pointer.

## Structure
- Package sram_arb_pkg holds:
  - address width 20 and data width 16 constants;
  - the state enum {ARB, LOCKED};
  - the request struct {write, addr, data}.
- One sub-module, sram_arb_tag_fifo: synchronous FIFO of $clog2(NUM_REQ)-bit indices, depth MAX_OUT, with simultaneous push/pop and full/empty/count outputs.

## Test plan
- Reset, then all four requesters issue reads continuously → grants in order 0,1,2,3,0; returns fed back in order → RespValid pulses in order 0,1,2,3,0 with the matching data.
- Requester 2 reads address 0x00012 while ReqValid=0 elsewhere; the return is 0xBEEF → RespValid[2] pulses 1 cycle after SramRespValid with RespData[2]=0xBEEF; Outstanding goes 0→1→0.
- 8 reads issued with no returns (MAX_OUT=8) → the 9th read is stalled (ReqReady=0), while a write from another requester is still granted. A return in the same cycle as the 9th read allows that read to be granted.
- SramFull held high for 5 cycles with all requesters valid → no ReqReady and no Sram*Req pulses; the grant resumes at the correct round-robin position.
- SramRespValid pulsed with Outstanding=0 → RespError goes to 1 and stays high; no RespValid pulse.
- With SRAM_ARB_BURST_EN, requester 1 locks for 6 beats while requester 3 is valid → requester 1 gets exactly 4 consecutive grants, then requester 3 is granted. Dropping ReqLock after 2 beats releases the grant immediately.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared widths, arbiter state encoding and the registered request payload
// for the SRAM port arbiter.
package sram_arb_pkg;

  localparam int unsigned ADDR_W = 20;
  localparam int unsigned DATA_W = 16;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sram_req_t;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester-side and SRAM-controller-side bundle for sram_port_arbiter.
// master: clients and controller (drive requests and returns);
// slave: the arbiter.
interface sram_port_arbiter_if
  import sram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned MAX_OUT = 8
);

  logic [NUM_REQ-1:0]             ReqValid;
  logic [NUM_REQ-1:0]             ReqWrite;
  logic [NUM_REQ-1:0]             ReqLock;
  logic [NUM_REQ-1:0][ADDR_W-1:0] ReqAddr;
  logic [NUM_REQ-1:0][DATA_W-1:0] ReqData;
  logic [NUM_REQ-1:0]             ReqReady;
  logic [NUM_REQ-1:0]             RespValid;
  logic [NUM_REQ-1:0][DATA_W-1:0] RespData;
  logic                           SramReadReq;
  logic                           SramWriteReq;
  logic [ADDR_W-1:0]              SramAddr;
  logic [DATA_W-1:0]              SramData;
  logic                           SramFull;
  logic                           SramRespValid;
  logic [DATA_W-1:0]              SramRespData;
  logic [$clog2(MAX_OUT):0]       Outstanding;
  logic                           RespError;

  modport master (
    output ReqValid, ReqWrite, ReqLock, ReqAddr, ReqData,
    output SramFull, SramRespValid, SramRespData,
    input  ReqReady, RespValid, RespData,
    input  SramReadReq, SramWriteReq, SramAddr, SramData,
    input  Outstanding, RespError
  );

  modport slave (
    input  ReqValid, ReqWrite, ReqLock, ReqAddr, ReqData,
    input  SramFull, SramRespValid, SramRespData,
    output ReqReady, RespValid, RespData,
    output SramReadReq, SramWriteReq, SramAddr, SramData,
    output Outstanding, RespError
  );

endinterface

// File: rtl/sram_arb_tag_fifo.sv
// In-order FIFO of requester indices for reads in flight. Push and pop in
// the same cycle are both honoured; a pop while empty is ignored.
module sram_arb_tag_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push_c, do_pop_c;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign do_pop_c  = pop_i && !empty_o;
  assign do_push_c = push_i && (!full_o || do_pop_c);
  assign head_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Storage array; contents are qualified by count so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push_c) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push_c, do_pop_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one SRAM controller request port between
// NUM_REQ requesters, with in-order read-return routing.
// Optional feature macro: SRAM_ARB_BURST_EN (locked bursts of up to
// BURST_LEN beats driven by ReqLock).
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_OUT   = 8
`ifdef SRAM_ARB_BURST_EN
  , parameter int unsigned BURST_LEN = 4
`endif
) (
  input logic                BOARD_CLK,
  input logic                RESET_N,
  sram_port_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_OUT) + 1;

  logic [NUM_REQ-1:0] elig_c, ready_c;
  logic               gnt_found_c, push_c;
  logic [IDX_W-1:0]   gnt_idx_c, cand_c, last_q, head_c;
  logic               fifo_full_c, fifo_empty_c;
  logic [CNT_W-1:0]   fifo_count_c;
  logic               locked_c;
  logic               valid_q;
  sram_req_t          req_q;
  logic [NUM_REQ-1:0]             resp_valid_q;
  logic [NUM_REQ-1:0][DATA_W-1:0] resp_data_q;
  logic                           err_q;

`ifdef SRAM_ARB_BURST_EN
  localparam int unsigned BEAT_W = $clog2(BURST_LEN + 1);

  arb_state_e        state_q, state_d;
  logic [BEAT_W-1:0] cnt_q, cnt_d;

  // The owner (last grantee) keeps the grant only while it still asks for it.
  assign locked_c = (state_q == LOCKED) && bus.ReqValid[last_q] && bus.ReqLock[last_q];

  // Burst FSM state register.
  always_ff @(posedge BOARD_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ARB;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Burst FSM next state: enter on a locked transfer, leave on the last beat or a release.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (locked_c) begin
      if (gnt_found_c) begin
        if (cnt_q == BEAT_W'(BURST_LEN - 1)) begin
          state_d = ARB;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + BEAT_W'(1);
        end
      end
    end else begin
      state_d = ARB;
      cnt_d   = '0;
      if (gnt_found_c && bus.ReqLock[gnt_idx_c] && (BURST_LEN > 1)) begin
        state_d = LOCKED;
        cnt_d   = BEAT_W'(1);
      end
    end
  end
`else
  logic unused_lock_c;
  assign unused_lock_c = ^bus.ReqLock;
  assign locked_c      = 1'b0;
`endif

  // Eligibility, optional owner mask, and round-robin search from last_q+1.
  always_comb begin
    elig_c      = '0;
    ready_c     = '0;
    gnt_found_c = 1'b0;
    gnt_idx_c   = last_q;
    cand_c      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      elig_c[i] = bus.ReqValid[i] && !bus.SramFull &&
                  (bus.ReqWrite[i] || !fifo_full_c || bus.SramRespValid);
    end
    if (locked_c) elig_c = elig_c & (NUM_REQ'(1) << last_q);
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand_c = IDX_W'((32'(last_q) + k) % NUM_REQ);
      if (!gnt_found_c && elig_c[cand_c]) begin
        gnt_found_c = 1'b1;
        gnt_idx_c   = cand_c;
      end
    end
    if (gnt_found_c) ready_c[gnt_idx_c] = 1'b1;
  end

  assign push_c = gnt_found_c && !bus.ReqWrite[gnt_idx_c];

  // Round-robin pointer and one-cycle issue register.
  always_ff @(posedge BOARD_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      last_q  <= IDX_W'(NUM_REQ - 1);
      valid_q <= 1'b0;
      req_q   <= '0;
    end else begin
      valid_q <= gnt_found_c;
      if (gnt_found_c) begin
        last_q <= gnt_idx_c;
        req_q  <= '{write: bus.ReqWrite[gnt_idx_c],
                    addr:  bus.ReqAddr[gnt_idx_c],
                    data:  bus.ReqData[gnt_idx_c]};
      end
    end
  end

  sram_arb_tag_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (MAX_OUT)
  ) u_tag_fifo (
    .clk         (BOARD_CLK),
    .rst_n       (RESET_N),
    .push_i      (push_c),
    .push_data_i (gnt_idx_c),
    .pop_i       (bus.SramRespValid),
    .head_o      (head_c),
    .full_o      (fifo_full_c),
    .empty_o     (fifo_empty_c),
    .count_o     (fifo_count_c)
  );

  // Route each read return to the requester at the head of the tag FIFO.
  always_ff @(posedge BOARD_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      resp_valid_q <= '0;
      if (bus.SramRespValid) begin
        if (fifo_empty_c) begin
          err_q <= 1'b1;
        end else begin
          resp_valid_q[head_c] <= 1'b1;
          resp_data_q[head_c]  <= bus.SramRespData;
        end
      end
    end
  end

  assign bus.ReqReady     = ready_c;
  assign bus.SramReadReq  = valid_q && !req_q.write;
  assign bus.SramWriteReq = valid_q && req_q.write;
  assign bus.SramAddr     = req_q.addr;
  assign bus.SramData     = req_q.data;
  assign bus.RespValid    = resp_valid_q;
  assign bus.RespData     = resp_data_q;
  assign bus.Outstanding  = fifo_count_c;
  assign bus.RespError    = err_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed self-checking bench for sram_port_arbiter (NUM_REQ=4, MAX_OUT=8).
module tb_sram_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  sram_port_arbiter_if #(.NUM_REQ(4), .MAX_OUT(8)) bus ();

  sram_port_arbiter #(.NUM_REQ(4), .MAX_OUT(8)) dut (
    .BOARD_CLK (clk),
    .RESET_N   (rst_n),
    .bus       (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    int exp_seq[5];
    exp_seq = '{0, 1, 2, 3, 0};

    bus.ReqValid = '0; bus.ReqWrite = '0; bus.ReqLock = '0;
    bus.SramFull = 1'b0; bus.SramRespValid = 1'b0; bus.SramRespData = '0;
    for (int i = 0; i < 4; i++) begin
      bus.ReqAddr[i] = 20'(32'h100 + i);
      bus.ReqData[i] = 16'(32'h5000 + i);
    end

    // Reset state
    repeat (3) tick();
    check("rst_ready", 32'(bus.ReqReady), 32'h0);
    check("rst_rdreq", 32'(bus.SramReadReq), 32'h0);
    check("rst_outst", 32'(bus.Outstanding), 32'h0);
    check("rst_err", 32'(bus.RespError), 32'h0);
    check("rst_rvalid", 32'(bus.RespValid), 32'h0);
    check("rst_rdata", 32'(bus.RespData[3]), 32'h0);
    rst_n = 1'b1;
    tick();

    // All four read continuously: grants 0,1,2,3,0
    bus.ReqValid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      settle();
      check($sformatf("rr_ready%0d", k), 32'(bus.ReqReady), 32'(1) << exp_seq[k]);
      tick();
      check($sformatf("rr_rdreq%0d", k), 32'(bus.SramReadReq), 32'h1);
      check($sformatf("rr_addr%0d", k), 32'(bus.SramAddr), 32'h100 + 32'(exp_seq[k]));
    end
    bus.ReqValid = '0;
    check("rr_outst", 32'(bus.Outstanding), 32'h5);
    for (int k = 0; k < 5; k++) begin
      bus.SramRespValid = 1'b1;
      bus.SramRespData  = 16'(32'hA000 + k);
      tick();
      check($sformatf("ret_valid%0d", k), 32'(bus.RespValid), 32'(1) << exp_seq[k]);
      check($sformatf("ret_data%0d", k), 32'(bus.RespData[exp_seq[k]]), 32'hA000 + 32'(k));
    end
    bus.SramRespValid = 1'b0;
    tick();
    check("ret_idle", 32'(bus.RespValid), 32'h0);
    check("ret_outst", 32'(bus.Outstanding), 32'h0);

    // Single read by requester 2
    bus.ReqAddr[2] = 20'h00012;
    bus.ReqValid   = 4'b0100;
    settle();
    check("r2_ready", 32'(bus.ReqReady), 32'h4);
    tick();
    bus.ReqValid = '0;
    check("r2_rdreq", 32'(bus.SramReadReq), 32'h1);
    check("r2_wrreq", 32'(bus.SramWriteReq), 32'h0);
    check("r2_addr", 32'(bus.SramAddr), 32'h12);
    check("r2_outst1", 32'(bus.Outstanding), 32'h1);
    bus.SramRespValid = 1'b1;
    bus.SramRespData  = 16'hBEEF;
    tick();
    bus.SramRespValid = 1'b0;
    check("r2_rvalid", 32'(bus.RespValid), 32'h4);
    check("r2_rdata", 32'(bus.RespData[2]), 32'hBEEF);
    check("r2_outst0", 32'(bus.Outstanding), 32'h0);
    tick();
    check("r2_pulse", 32'(bus.RespValid), 32'h0);
    check("r2_hold", 32'(bus.RespData[2]), 32'hBEEF);

    // Fill the tag FIFO with 8 reads from requester 0
    bus.ReqValid = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      settle();
      check($sformatf("fill_ready%0d", k), 32'(bus.ReqReady), 32'h1);
      tick();
    end
    check("fill_outst", 32'(bus.Outstanding), 32'h8);
    bus.ReqValid = 4'b0011;
    bus.ReqWrite = 4'b0010;
    settle();
    check("full_wr_ready", 32'(bus.ReqReady), 32'h2);
    tick();
    check("full_wrreq", 32'(bus.SramWriteReq), 32'h1);
    check("full_rdreq", 32'(bus.SramReadReq), 32'h0);
    check("full_wr_outst", 32'(bus.Outstanding), 32'h8);
    bus.ReqValid = 4'b0001;
    bus.ReqWrite = '0;
    settle();
    check("full_stall", 32'(bus.ReqReady), 32'h0);
    bus.SramRespValid = 1'b1;
    bus.SramRespData  = 16'h1111;
    settle();
    check("full_pop_ready", 32'(bus.ReqReady), 32'h1);
    tick();
    bus.ReqValid = '0;
    check("full_pp_rdreq", 32'(bus.SramReadReq), 32'h1);
    check("full_pp_outst", 32'(bus.Outstanding), 32'h8);
    check("full_pp_rvalid", 32'(bus.RespValid), 32'h1);
    check("full_pp_rdata", 32'(bus.RespData[0]), 32'h1111);
    for (int k = 0; k < 8; k++) begin
      bus.SramRespData = 16'(32'h3000 + k);
      tick();
    end
    bus.SramRespValid = 1'b0;
    check("drain_rdata", 32'(bus.RespData[0]), 32'h3007);
    check("drain_outst", 32'(bus.Outstanding), 32'h0);
    tick();

    // SramFull back-pressure, then resume at requester 1
    bus.SramFull = 1'b1;
    bus.ReqValid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      settle();
      check($sformatf("sfull_ready%0d", k), 32'(bus.ReqReady), 32'h0);
      tick();
      check($sformatf("sfull_req%0d", k), 32'({bus.SramReadReq, bus.SramWriteReq}), 32'h0);
    end
    bus.SramFull = 1'b0;
    settle();
    check("resume_ready", 32'(bus.ReqReady), 32'h2);
    tick();
    bus.ReqValid = '0;
    check("resume_addr", 32'(bus.SramAddr), 32'h101);
    bus.SramRespValid = 1'b1;
    bus.SramRespData  = 16'h2222;
    tick();
    bus.SramRespValid = 1'b0;
    check("resume_rvalid", 32'(bus.RespValid), 32'h2);
    check("resume_rdata", 32'(bus.RespData[1]), 32'h2222);
    tick();

    // Return with nothing outstanding
    check("err_pre", 32'(bus.RespError), 32'h0);
    bus.SramRespValid = 1'b1;
    bus.SramRespData  = 16'hDEAD;
    tick();
    bus.SramRespValid = 1'b0;
    check("err_set", 32'(bus.RespError), 32'h1);
    check("err_novalid", 32'(bus.RespValid), 32'h0);
    tick();
    tick();
    check("err_sticky", 32'(bus.RespError), 32'h1);
    check("err_data_kept", 32'(bus.RespData[1]), 32'h2222);

`ifdef SRAM_ARB_BURST_EN
    // Requester 1 locks a long burst; bounded to 4 beats, then requester 3
    bus.ReqWrite = 4'b1010;
    bus.ReqLock  = 4'b0010;
    bus.ReqValid = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      settle();
      check($sformatf("burst_ready%0d", k), 32'(bus.ReqReady), 32'h2);
      tick();
      check($sformatf("burst_wr%0d", k), 32'(bus.SramWriteReq), 32'h1);
      bus.ReqValid = 4'b1010;
    end
    settle();
    check("burst_end_ready", 32'(bus.ReqReady), 32'h8);
    tick();
    check("burst_end_addr", 32'(bus.SramAddr), 32'h103);
    // Dropping ReqLock after 2 beats hands over immediately
    bus.ReqValid = 4'b0010;
    settle();
    check("drop_ready0", 32'(bus.ReqReady), 32'h2);
    tick();
    bus.ReqValid = 4'b1010;
    settle();
    check("drop_ready1", 32'(bus.ReqReady), 32'h2);
    tick();
    bus.ReqLock = '0;
    settle();
    check("drop_release", 32'(bus.ReqReady), 32'h8);
    tick();
    check("drop_addr", 32'(bus.SramAddr), 32'h103);
`else
    // ReqLock has no effect: writes from 1 and 3 alternate
    bus.ReqWrite = 4'b1010;
    bus.ReqLock  = 4'b0010;
    bus.ReqValid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      settle();
      check($sformatf("nolock_ready%0d", k), 32'(bus.ReqReady), (k % 2 == 0) ? 32'h8 : 32'h2);
      tick();
      check($sformatf("nolock_wr%0d", k), 32'(bus.SramWriteReq), 32'h1);
      check($sformatf("nolock_data%0d", k), 32'(bus.SramData), (k % 2 == 0) ? 32'h5003 : 32'h5001);
    end
`endif
    bus.ReqValid = '0;
    bus.ReqLock  = '0;
    tick();
    check("end_idle", 32'({bus.SramReadReq, bus.SramWriteReq}), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
